// File: rtl/video_timing_pkg.sv
// Shared 1080p60 raster constants and the sync bundle carried through the
// alignment delay line.
package video_timing_pkg;

    localparam int H_ACTIVE      = 1920;
    localparam int H_FRONT_PORCH = 88;
    localparam int H_SYNC_WIDTH  = 44;
    localparam int H_BACK_PORCH  = 148;
    localparam int V_ACTIVE      = 1080;
    localparam int V_FRONT_PORCH = 4;
    localparam int V_SYNC_WIDTH  = 5;
    localparam int V_BACK_PORCH  = 36;

    // Totals follow from the segments: 2200 pixels and 1125 lines.
    localparam int H_TOTAL = H_ACTIVE + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_bus_t;

endpackage

// File: rtl/sync_delay_line.sv
// Reset-to-zero shift register of configurable depth; DEPTH=0 is a straight
// bypass.
module sync_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_bypass
        assign q = d;
    end else begin : g_shift
        logic [WIDTH-1:0] stage_q [DEPTH];
        logic [WIDTH-1:0] stage_d [DEPTH];

        always_comb begin
            stage_d[0] = d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end

        // NOTE: this array is reset on purpose so a reset mid-line cannot
        // replay stale syncs or data-enable after release.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stage_q <= '{default: '0};
            end else begin
                stage_q <= stage_d;
            end
        end

        assign q = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster counter, sync decode and image-change scheduling; syncs and rgb are
// realigned to the image controller latency before leaving the block.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int FRAME_WIDTH   = H_TOTAL,
    parameter int FRAME_HEIGHT  = V_TOTAL,
    parameter int SCREEN_WIDTH  = H_ACTIVE,
    parameter int SCREEN_HEIGHT = V_ACTIVE,
    parameter int H_FRONT       = H_FRONT_PORCH,
    parameter int H_SYNC        = H_SYNC_WIDTH,
    parameter int V_FRONT       = V_FRONT_PORCH,
    parameter int V_SYNC        = V_SYNC_WIDTH,
    parameter int BIT_WIDTH     = 12,
    parameter int BIT_HEIGHT    = 11,
    parameter int RGB_LATENCY   = 2
) (
    input  logic                  s_axi_aclk,
    input  logic                  s_axi_aresetn,
    input  logic                  enable,
    input  logic                  change_req,
    input  logic [23:0]           rgb_in,
    output logic [BIT_WIDTH-1:0]  cx,
    output logic [BIT_HEIGHT-1:0] cy,
    output logic                  image_change,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  de_out,
    output logic [23:0]           rgb_out,
    output logic [31:0]           frame_count
);

    localparam logic [BIT_WIDTH-1:0]  CX_LAST   = BIT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [BIT_WIDTH-1:0]  CX_ACTIVE = BIT_WIDTH'(SCREEN_WIDTH);
    localparam logic [BIT_WIDTH-1:0]  HS_START  = BIT_WIDTH'(SCREEN_WIDTH + H_FRONT);
    localparam logic [BIT_WIDTH-1:0]  HS_END    = BIT_WIDTH'(SCREEN_WIDTH + H_FRONT + H_SYNC);
    localparam logic [BIT_HEIGHT-1:0] CY_LAST   = BIT_HEIGHT'(FRAME_HEIGHT - 1);
    localparam logic [BIT_HEIGHT-1:0] CY_ACTIVE = BIT_HEIGHT'(SCREEN_HEIGHT);
    localparam logic [BIT_HEIGHT-1:0] VS_START  = BIT_HEIGHT'(SCREEN_HEIGHT + V_FRONT);
    localparam logic [BIT_HEIGHT-1:0] VS_END    = BIT_HEIGHT'(SCREEN_HEIGHT + V_FRONT + V_SYNC);
    localparam int                    BUS_W     = $bits(sync_bus_t) + 24;

    logic                  run_q, run_d;
    logic [BIT_WIDTH-1:0]  cx_q, cx_d;
    logic [BIT_HEIGHT-1:0] cy_q, cy_d;
    logic [31:0]           frame_count_q, frame_count_d;
    logic                  image_change_q, image_change_d;
    logic                  pending_q, pending_d;
    logic                  active;
    logic                  vblank_start;
    sync_bus_t             sync_raw;
    sync_bus_t             sync_dly;
    logic [23:0]           rgb_dly;

    // The cycle enable rises, the counters are parked at the origin, so only
    // the following cycle is treated as pixel (0,0).
    assign active = enable & run_q;

    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave
        // one unassigned and infer a latch.
        run_d          = enable;
        cx_d           = cx_q;
        cy_d           = cy_q;
        frame_count_d  = frame_count_q;
        image_change_d = 1'b0;
        pending_d      = pending_q | change_req;
        vblank_start   = 1'b0;
        sync_raw       = '0;

        if (!enable) begin
            cx_d = '0;
            cy_d = '0;
        end else if (run_q) begin
            if (cx_q == CX_LAST) begin
                cx_d = '0;
                if (cy_q == CY_LAST) begin
                    cy_d          = '0;
                    frame_count_d = frame_count_q + 32'd1;
                end else begin
                    cy_d = cy_q + BIT_HEIGHT'(1);
                end
            end else begin
                cx_d = cx_q + BIT_WIDTH'(1);
            end
        end

        // A request landing on the blanking cycle itself is consumed here.
        vblank_start = active && (cx_q == '0) && (cy_q == CY_ACTIVE);
        if (vblank_start) begin
            image_change_d = pending_q | change_req;
            pending_d      = 1'b0;
        end

        sync_raw.de = active && (cx_q < CX_ACTIVE) && (cy_q < CY_ACTIVE);
        sync_raw.hs = active && (cx_q >= HS_START) && (cx_q < HS_END);
        sync_raw.vs = active && (cy_q >= VS_START) && (cy_q < VS_END);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            run_q          <= 1'b0;
            cx_q           <= '0;
            cy_q           <= '0;
            frame_count_q  <= '0;
            image_change_q <= 1'b0;
            pending_q      <= 1'b0;
        end else begin
            run_q          <= run_d;
            cx_q           <= cx_d;
            cy_q           <= cy_d;
            frame_count_q  <= frame_count_d;
            image_change_q <= image_change_d;
            pending_q      <= pending_d;
        end
    end

    sync_delay_line #(
        .DEPTH (RGB_LATENCY),
        .WIDTH (BUS_W)
    ) u_delay (
        .clk   (s_axi_aclk),
        .rst_n (s_axi_aresetn),
        .d     ({sync_raw, rgb_in}),
        .q     ({sync_dly, rgb_dly})
    );

    assign cx           = cx_q;
    assign cy           = cy_q;
    assign frame_count  = frame_count_q;
    assign image_change = image_change_q;
    assign hsync_out    = sync_dly.hs;
    assign vsync_out    = sync_dly.vs;
    assign de_out       = sync_dly.de;
    assign rgb_out      = sync_dly.de ? rgb_dly : 24'd0;

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Raster timing generator that drives the pixel-coordinate side of the image path. It produces `cx`/`cy` for the image controller, issues the frame-aligned `image_change` pulse, and realigns hsync/vsync/de with the returned `rgb` so that a downstream TMDS/HDMI encoder receives a coherent pixel stream. It runs in the same clock domain as the image controller.

## Interface
- `FRAME_WIDTH`, 2200: total pixels per line.
- `FRAME_HEIGHT`, 1125: total lines per frame.
- `SCREEN_WIDTH`, 1920: active pixels per line.
- `SCREEN_HEIGHT`, 1080: active lines.
- `H_FRONT`, 88: horizontal front porch.
- `H_SYNC`, 44: horizontal sync width.
- `V_FRONT`, 4: vertical front porch, in lines.
- `V_SYNC`, 5: vertical sync width, in lines.
- `BIT_WIDTH`, 12: width of `cx`.
- `BIT_HEIGHT`, 11: width of `cy`.
- `RGB_LATENCY`, 2: cycles from `cx`/`cy` to a valid `rgb_in`; legal range 0..15.

Ports:
- `s_axi_aclk` in 1: pixel clock, shared with the image controller.
- `s_axi_aresetn` in 1: asynchronous active-low reset.
- `enable` in 1: raster runs while high; tied to `auto_start`.
- `change_req` in 1: one-cycle request to advance to the next image.
- `rgb_in` in 24: pixel returned by the image controller.
- `cx` out BIT_WIDTH: current column, 0..FRAME_WIDTH-1.
- `cy` out BIT_HEIGHT: current line, 0..FRAME_HEIGHT-1.
- `image_change` out 1: one-cycle pulse to the image controller.
- `hsync_out`, `vsync_out`, `de_out` out 1 each: syncs and data-enable, delayed by RGB_LATENCY.
- `rgb_out` out 24: `rgb_in` when `de_out` is high, else 0.
- `frame_count` out 32: number of completed frames.

## Operation
- All outputs reset to 0. The change-pending flag and the delay line also reset to 0.
- Counters:
  - `cx` increments every cycle while `enable` is high.
  - At FRAME_WIDTH-1, `cx` wraps to 0 and `cy` increments.
  - At (FRAME_WIDTH-1, FRAME_HEIGHT-1), both wrap to 0 and `frame_count` increments, wrapping modulo 2^32.
- When `enable` is low, `cx`/`cy` clear to 0 on the next cycle and hold. `frame_count` holds its value.
- A rising edge on `enable` starts the raster at (0,0).
- Raw timing is decoded from `cx`/`cy` in the same cycle:
  - de_raw = `enable` & `cx` < SCREEN_WIDTH & `cy` < SCREEN_HEIGHT.
  - hs_raw = `cx` in [SCREEN_WIDTH+H_FRONT, SCREEN_WIDTH+H_FRONT+H_SYNC).
  - vs_raw = `cy` in [SCREEN_HEIGHT+V_FRONT, SCREEN_HEIGHT+V_FRONT+V_SYNC).
  - Syncs are active-high. hs_raw and vs_raw are forced to 0 when `enable` is low.
- Image change:
  - `change_req` sets the pending flag.
  - At `cx`==0 and `cy`==SCREEN_HEIGHT (first cycle of vertical blanking), with `enable` high: if pending | `change_req`, assert `image_change` for one cycle and clear pending.
  - A request arriving in that same cycle is absorbed by the pulse and is not carried over.
  - Multiple requests within one frame collapse into a single pulse.
- Delay alignment: hs_raw, vs_raw and de_raw pass through an RGB_LATENCY-deep shift register to become `hsync_out`, `vsync_out` and `de_out`.
- `rgb_out` is registered alongside them and uses the delayed `de`.
- With RGB_LATENCY=0 the shift register is a bypass. `rgb_out` is then `rgb_in` gated combinationally by `de_out`.

## Timing
- `cx`, `cy`, `image_change` and `frame_count` are registered outputs.
- `hsync_out`, `vsync_out`, `de_out` and `rgb_out` lag the `cx`/`cy` that produced them by exactly RGB_LATENCY cycles.
- The first active pixel after reset release with `enable` high:
  - `cx`=0 in cycle 1.
  - `de_out` high in cycle 1+RGB_LATENCY.
- `enable` deasserted mid-line:
  - Counters go to 0 the next cycle.
  - The delay line keeps draining, so de/syncs fall RGB_LATENCY cycles later.
  - Pending is kept.
- Asynchronous reset mid-frame clears everything immediately, including the delay line. There is no partial pulse.
- `image_change` occurs at most once per frame: period ≥ FRAME_WIDTH*FRAME_HEIGHT cycles.

## Structure
- `video_timing_pkg` holds:
  - the 1080p60 constants (2200/1125/1920/1080/88/44/148/4/5/36);
  - the `sync_bus_t` packed struct {hs, vs, de}.
- Sub-module `sync_delay_line`, parameterised on depth and width. It is a reset-to-0 shift register and is used once for {`sync_bus_t`, rgb}.
- Top level: counters, decode, pending logic.

## Test plan
- Reset release, `enable`=1, RGB_LATENCY=2 -> `cx` reaches 1919 at cycle 1920. `de_out` is high in cycles 3..1922 and falls at cycle 1923.
- Run one line -> `hsync_out` is high for exactly 44 cycles, starting 2008+2 cycles after `cx`=0. One full frame -> `vsync_out` is high for 5×2200 cycles. `frame_count`=1 after 2,475,000 cycles.
- `change_req` pulse at `cy`=10 -> a single `image_change` at (`cx`=0, `cy`=1080). No pulse in the next frame without a new request.
- `change_req` exactly at (`cx`=0, `cy`=1080) with pending=0 -> `image_change` fires that cycle and no pulse follows in the next frame.
- Three `change_req` pulses in one frame -> exactly one `image_change`.
- `enable` dropped at `cx`=500 -> `cx`/`cy`=0 the next cycle and `de_out` falls 2 cycles later. Async reset at `cy`=1080 -> all outputs 0 immediately and `frame_count`=0.
